// File: rtl/fft_frame_loader.sv
// Collects complex samples into a shadow buffer and launches whole frames to the
// FFT butterfly core, one frame in flight while the next one fills.
module fft_frame_loader #(
    parameter int N_POINTS       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [15:0]  s_real,
    input  logic [15:0]  s_imag,
    output logic [255:0] frame_real,
    output logic [255:0] frame_imag,
    output logic         new_input_flag,
    input  logic         fft_ready_flag,
    output logic [15:0]  frame_count,
    output logic         timeout_err
);

    localparam int IDX_W  = $clog2(N_POINTS);
    localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_POINTS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              shadow_full_q, shadow_full_d;
    logic [15:0]       shadow_real_q [N_POINTS];
    logic [15:0]       shadow_real_d [N_POINTS];
    logic [15:0]       shadow_imag_q [N_POINTS];
    logic [15:0]       shadow_imag_d [N_POINTS];
    logic [15:0]       frame_real_q  [N_POINTS];
    logic [15:0]       frame_real_d  [N_POINTS];
    logic [15:0]       frame_imag_q  [N_POINTS];
    logic [15:0]       frame_imag_d  [N_POINTS];
    logic              toggle_q, toggle_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fft_rdy_q, fft_rdy_d;

    logic accept;
    logic fft_rise;

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        shadow_full_d = shadow_full_q;
        shadow_real_d = shadow_real_q;
        shadow_imag_d = shadow_imag_q;
        frame_real_d  = frame_real_q;
        frame_imag_d  = frame_imag_q;
        toggle_d      = toggle_q;
        count_d       = count_q;
        err_d         = err_q;
        wait_d        = wait_q;
        fft_rdy_d     = fft_ready_flag;

        accept   = s_valid && !shadow_full_q;
        fft_rise = fft_ready_flag && !fft_rdy_q;

        // Filling is independent of the launch FSM; a full shadow simply stalls upstream.
        if (accept) begin
            shadow_real_d[wr_idx_q] = s_real;
            shadow_imag_d[wr_idx_q] = s_imag;
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d      = '0;
                shadow_full_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        case (state_q)
            ST_READY: begin
                if (shadow_full_q) begin
                    state_d       = ST_BUSY;
                    frame_real_d  = shadow_real_q;
                    frame_imag_d  = shadow_imag_q;
                    toggle_d      = ~toggle_q;
                    count_d       = count_q + 16'd1;
                    shadow_full_d = 1'b0;
                    wait_d        = '0;
                end
            end
            ST_BUSY: begin
                // A result arriving on the last wait cycle wins over the timeout.
                if (fft_rise) begin
                    state_d = ST_READY;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_READY;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_READY;
            wr_idx_q      <= '0;
            shadow_full_q <= 1'b0;
            toggle_q      <= 1'b0;
            count_q       <= '0;
            err_q         <= 1'b0;
            wait_q        <= '0;
            fft_rdy_q     <= 1'b0;
            for (int k = 0; k < N_POINTS; k++) begin
                shadow_real_q[k] <= '0;
                shadow_imag_q[k] <= '0;
                frame_real_q[k]  <= '0;
                frame_imag_q[k]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            shadow_full_q <= shadow_full_d;
            toggle_q      <= toggle_d;
            count_q       <= count_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            fft_rdy_q     <= fft_rdy_d;
            shadow_real_q <= shadow_real_d;
            shadow_imag_q <= shadow_imag_d;
            frame_real_q  <= frame_real_d;
            frame_imag_q  <= frame_imag_d;
        end
    end

    // Unused upper words of the 16-point bus are tied to zero.
    always_comb begin
        frame_real = '0;
        frame_imag = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            frame_real[16*k +: 16] = frame_real_q[k];
            frame_imag[16*k +: 16] = frame_imag_q[k];
        end
    end

    assign s_ready        = ~shadow_full_q;
    assign new_input_flag = toggle_q;
    assign frame_count    = count_q;
    assign timeout_err    = err_q;

endmodule
